// File: rtl/ch0re_pkg.sv
// Shared types and constants for the ch0re fetch stage.
package ch0re_pkg;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RV_NOP        = 32'h0000_0013;
  localparam int          FETCH_ENTRY_W = 64 + 32 + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/ch0re_fetch_fifo.sv
// Synchronous FIFO with flush; write at posedge, head visible the next cycle, no bypass.
// Push into a full queue is accepted only alongside a pop; pop of an empty queue is ignored.
module ch0re_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_count = count_q;
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = i_pop & ~o_empty;
    do_push  = i_push & (~o_full | do_pop);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_wdata;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ch0re_ifetch.sv
// Stage-1 fetch: request in cycle N, entry valid to decode in N+2, one instr/cycle sustained.
// Issue throttles on queue occupancy + in-flight so the queue never overflows under i_ready=0.
module ch0re_ifetch
  import ch0re_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          IMEM_DEPTH      = 2048,
  parameter int          IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH),
  parameter int          FIFO_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       o_imem_en,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [31:0]                i_imem_rdata,
  input  logic                       i_redirect,
  input  logic [63:0]                i_redirect_pc,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [63:0]                o_pc,
  output logic [31:0]                o_instr,
  output logic                       o_exc_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t             state_q, state_d;
  logic [63:0]              pc_q, pc_d;
  logic [63:0]              req_pc_q, req_pc_d;
  logic                     inflight_q, inflight_d;

  logic [FETCH_ENTRY_W-1:0] fifo_rdata;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_full, fifo_empty;
  fetch_entry_t             head, push_entry;
  logic                     pop, push, resp_push, exc_push, issue, run, aligned, has_space;
  logic [CW:0]              occ;

  assign head        = fetch_entry_t'(fifo_rdata);
  assign o_valid     = ~fifo_empty & ~i_redirect & ~rst;
  assign o_imem_en   = issue;
  assign o_imem_addr = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign o_pc             = fifo_empty ? 64'h0 : head.pc;
  assign o_instr          = fifo_empty ? 32'h0 : head.instr;
  assign o_exc_misaligned = fifo_empty ? 1'b0  : head.exc;

  always_comb begin
    pop       = o_valid & i_ready;
    occ       = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    has_space = occ < (CW+1)'(FIFO_DEPTH);
    aligned   = (pc_q[1:0] == 2'b00);
    run       = (state_q == FETCH_RUN) & ~i_redirect & ~rst;
    issue     = run & aligned & has_space;
    // The exception entry waits for any older response to land first.
    exc_push  = run & ~aligned & ~inflight_q & (~fifo_full | pop);
    resp_push = inflight_q & ~i_redirect;
    push      = resp_push | exc_push;

    push_entry = '{pc: req_pc_q, instr: i_imem_rdata, exc: 1'b0};
    if (exc_push) push_entry = '{pc: pc_q, instr: RV_NOP, exc: 1'b1};

    pc_d       = pc_q;
    state_d    = state_q;
    inflight_d = issue;
    req_pc_d   = issue ? pc_q : req_pc_q;
    if (i_redirect) begin
      pc_d    = i_redirect_pc;
      state_d = FETCH_RUN;
    end else begin
      if (issue)    pc_d    = pc_q + 64'd4;
      if (exc_push) state_d = FETCH_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= 64'h0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  ch0re_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_redirect),
    .i_push  (push),
    .i_wdata (push_entry),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Directed bench for ch0re_ifetch with a synchronous imem model.
module tb_ch0re_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_imem_en;
  logic [10:0] o_imem_addr;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        i_redirect = 1'b0;
  logic [63:0] i_redirect_pc = 64'h0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [63:0] o_pc;
  logic [31:0] o_instr;
  logic        o_exc_misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ch0re_ifetch dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_en        (o_imem_en),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rdata     (i_imem_rdata),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_pc             (o_pc),
    .o_instr          (o_instr),
    .o_exc_misaligned (o_exc_misaligned)
  );

  function automatic logic [31:0] word(input logic [10:0] a);
    return {16'hC0DE, 5'd0, a};
  endfunction

  always @(posedge clk) begin
    if (o_imem_en) i_imem_rdata <= word(o_imem_addr);
  end

  // Leaves the bench #1 after the negedge of the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1; i_redirect = 1'b0; i_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
  endtask

  task automatic next_cycle();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_ready = 1'b1; i_redirect = 1'b0;
    @(negedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en got=%b exp=0", o_imem_en); end
    checks++; if (o_exc_misaligned !== 1'b0) begin errors++; $display("FAIL reset_exc got=%b exp=0", o_exc_misaligned); end
    checks++; if (o_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
    checks++; if (o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", o_instr); end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 11'd0) begin errors++; $display("FAIL reset_first_req en=%b addr=%0d exp en=1 addr=0", o_imem_en, o_imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 11'(c)) begin errors++; $display("FAIL stream_req c=%0d en=%b addr=%0d exp addr=%0d", c, o_imem_en, o_imem_addr, c); end
      if (c < 2) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, o_valid); end
      end else begin
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 64'(4*(c-2)) || o_instr !== word(11'(c-2))) begin
          errors++; $display("FAIL stream_out c=%0d valid=%b pc=%h instr=%h exp pc=%h instr=%h", c, o_valid, o_pc, o_instr, 64'(4*(c-2)), word(11'(c-2)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    do_reset();
    next_cycle();
    @(negedge clk); i_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 64'h0 || o_imem_en !== 1'b0) begin
        errors++; $display("FAIL stall_hold k=%0d valid=%b pc=%h en=%b exp valid=1 pc=0 en=0", k, o_valid, o_pc, o_imem_en);
      end
      @(negedge clk);
      if (k == 4) i_ready = 1'b1;
      #1;
    end
    checks++; if (o_pc !== 64'h0 || o_imem_en !== 1'b1 || o_imem_addr !== 11'd2) begin errors++; $display("FAIL stall_release pc=%h en=%b addr=%0d exp pc=0 en=1 addr=2", o_pc, o_imem_en, o_imem_addr); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'h4 || o_instr !== word(11'd1)) begin errors++; $display("FAIL stall_next4 valid=%b pc=%h instr=%h exp pc=4", o_valid, o_pc, o_instr); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'h8 || o_instr !== word(11'd2)) begin errors++; $display("FAIL stall_next8 valid=%b pc=%h instr=%h exp pc=8", o_valid, o_pc, o_instr); end
  endtask

  task automatic test_redirect();
    do_reset();
    next_cycle();
    @(negedge clk); i_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 64'h100; #1;
    checks++; if (o_valid !== 1'b0 || o_imem_en !== 1'b0) begin errors++; $display("FAIL redir_cycle valid=%b en=%b exp 0 0", o_valid, o_imem_en); end
    @(negedge clk); i_redirect = 1'b0; i_ready = 1'b1; #1;
    checks++; if (o_valid !== 1'b0 || o_imem_en !== 1'b1 || o_imem_addr !== 11'h40) begin errors++; $display("FAIL redir_fetch valid=%b en=%b addr=%h exp 0 1 40", o_valid, o_imem_en, o_imem_addr); end
    next_cycle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_stale valid=%b exp=0", o_valid); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'h100 || o_instr !== word(11'h40)) begin errors++; $display("FAIL redir_target pc=%h instr=%h exp pc=100", o_pc, o_instr); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'h104 || o_instr !== word(11'h41)) begin errors++; $display("FAIL redir_target_next pc=%h instr=%h exp pc=104", o_pc, o_instr); end
  endtask

  task automatic test_misaligned();
    @(negedge clk); i_redirect = 1'b1; i_redirect_pc = 64'h102; #1;
    checks++; if (o_valid !== 1'b0 || o_imem_en !== 1'b0) begin errors++; $display("FAIL mis_redir valid=%b en=%b exp 0 0", o_valid, o_imem_en); end
    @(negedge clk); i_redirect = 1'b0; #1;
    checks++; if (o_valid !== 1'b0 || o_imem_en !== 1'b0) begin errors++; $display("FAIL mis_noissue valid=%b en=%b exp 0 0", o_valid, o_imem_en); end
    next_cycle();
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 64'h102 || o_instr !== 32'h0000_0013 || o_exc_misaligned !== 1'b1 || o_imem_en !== 1'b0) begin
      errors++; $display("FAIL mis_entry valid=%b pc=%h instr=%h exc=%b en=%b exp 1 102 13 1 0", o_valid, o_pc, o_instr, o_exc_misaligned, o_imem_en);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      checks++; if (o_valid !== 1'b0 || o_imem_en !== 1'b0) begin errors++; $display("FAIL mis_halt k=%0d valid=%b en=%b exp 0 0", k, o_valid, o_imem_en); end
    end
    @(negedge clk); i_redirect = 1'b1; i_redirect_pc = 64'h200; #1;
    @(negedge clk); i_redirect = 1'b0; #1;
    checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 11'h80) begin errors++; $display("FAIL mis_resume en=%b addr=%h exp 1 80", o_imem_en, o_imem_addr); end
    next_cycle();
    next_cycle();
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 64'h200 || o_exc_misaligned !== 1'b0 || o_instr !== word(11'h80)) begin
      errors++; $display("FAIL mis_resume_out valid=%b pc=%h exc=%b instr=%h exp pc=200 exc=0", o_valid, o_pc, o_exc_misaligned, o_instr);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    next_cycle();
    @(negedge clk); i_ready = 1'b0; #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_pre valid=%b exp=1", o_valid); end
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; i_ready = 1'b1; #1;
    checks++; if (o_valid !== 1'b0 || o_imem_en !== 1'b1 || o_imem_addr !== 11'd0) begin errors++; $display("FAIL mid_restart valid=%b en=%b addr=%0d exp 0 1 0", o_valid, o_imem_en, o_imem_addr); end
    next_cycle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_stale valid=%b exp=0", o_valid); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'h0 || o_instr !== word(11'd0)) begin errors++; $display("FAIL mid_first pc=%h instr=%h exp pc=0", o_pc, o_instr); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'h4) begin errors++; $display("FAIL mid_second pc=%h exp=4", o_pc); end
  endtask

  task automatic test_wrap();
    @(negedge clk); i_redirect = 1'b1; i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    @(negedge clk); i_redirect = 1'b0; #1;
    checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 11'h7FF) begin errors++; $display("FAIL wrap_top en=%b addr=%h exp 1 7ff", o_imem_en, o_imem_addr); end
    next_cycle();
    checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 11'h000) begin errors++; $display("FAIL wrap_zero en=%b addr=%h exp 1 0", o_imem_en, o_imem_addr); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'hFFFF_FFFF_FFFF_FFFC || o_instr !== word(11'h7FF)) begin errors++; $display("FAIL wrap_out_top pc=%h instr=%h exp pc=fffffffffffffffc", o_pc, o_instr); end
    next_cycle();
    checks++; if (o_valid !== 1'b1 || o_pc !== 64'h0 || o_instr !== word(11'h000)) begin errors++; $display("FAIL wrap_out_zero pc=%h instr=%h exp pc=0", o_pc, o_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_reset_midstream();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
